// File: rtl/conv_layer_sequencer.sv
// Convolution layer sequencer: weight/bias preload, activation stream with downstream hold,
// output-buffer write counting, and overrun detection. States: IDLE | LOAD | DRAIN | STREAM | FIN.
module conv_layer_sequencer #(
   parameter int N         = 21504,
   parameter int K         = 32,
   parameter int CHAN      = 4,
   parameter int OUTLEN    = 2562,
   parameter int ROM_LAT   = 1,
   parameter int FLUSH_MAX = 64,
   localparam int WT_W = (K*CHAN > 1) ? $clog2(K*CHAN) : 1,
   localparam int BI_W = (CHAN > 1)   ? $clog2(CHAN)   : 1,
   localparam int AC_W = (N > 1)      ? $clog2(N)      : 1,
   localparam int OB_W = (OUTLEN > 1) ? $clog2(OUTLEN) : 1
) (
   input  logic            clk,
   input  logic            global_rst,
   input  logic            start,
   input  logic            hold,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            wt_en,
   output logic [WT_W-1:0] wt_addr,
   output logic            wt_load,
   output logic            bias_en,
   output logic [BI_W-1:0] bias_addr,
   output logic            bias_load,
   output logic            act_en,
   output logic [AC_W-1:0] act_addr,
   input  logic            conv_valid,
   output logic            obuf_we,
   output logic [OB_W-1:0] obuf_addr
);
   // state    | meaning
   // IDLE     | waiting for start, all enables low
   // LOAD     | weight (and initially bias) ROM reads, one address per cycle
   // DRAIN    | ROM_LAT cycles for the last reads to land
   // STREAM   | activation stream, output writes counted
   // FIN      | one-cycle completion, done pulses unless overrun
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_DRAIN  = 3'd2;
   localparam logic [2:0] S_STREAM = 3'd3;
   localparam logic [2:0] S_FIN    = 3'd4;

   localparam int FL_W = (FLUSH_MAX > 0) ? $clog2(FLUSH_MAX + 1) : 1;
   localparam int DR_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   localparam logic [WT_W-1:0] WT_LAST = WT_W'(K*CHAN - 1);
   localparam logic [BI_W-1:0] BI_LAST = BI_W'(CHAN - 1);
   localparam logic [AC_W-1:0] AC_LAST = AC_W'(N - 1);
   localparam logic [OB_W-1:0] OB_LAST = OB_W'(OUTLEN - 1);
   localparam logic [FL_W-1:0] FL_INIT = FL_W'(FLUSH_MAX);
   localparam logic [DR_W-1:0] DR_INIT = DR_W'(ROM_LAT - 1);

   logic [2:0]         state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               wt_en_q, wt_en_d;
   logic [WT_W-1:0]    wt_addr_q, wt_addr_d;
   logic               bias_en_q, bias_en_d;
   logic [BI_W-1:0]    bias_addr_q, bias_addr_d;
   logic               act_en_q, act_en_d;
   logic [AC_W-1:0]    act_addr_q, act_addr_d;
   logic               sat_q, sat_d;
   logic [FL_W-1:0]    flush_q, flush_d;
   logic [DR_W-1:0]    drain_q, drain_d;
   logic [OB_W-1:0]    cnt_q, cnt_d;
   logic [ROM_LAT-1:0] wt_pipe_q, wt_pipe_d;
   logic [ROM_LAT-1:0] bias_pipe_q, bias_pipe_d;
   logic               wr;
   logic               overrun;

   assign wr = (state_q == S_STREAM) && conv_valid;

   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      done_d      = 1'b0;
      wt_en_d     = wt_en_q;
      wt_addr_d   = wt_addr_q;
      bias_en_d   = bias_en_q;
      bias_addr_d = bias_addr_q;
      act_en_d    = act_en_q;
      act_addr_d  = act_addr_q;
      sat_d       = sat_q;
      flush_d     = flush_q;
      drain_d     = drain_q;
      cnt_d       = cnt_q;
      overrun     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LOAD;
               err_d       = 1'b0;
               wt_en_d     = 1'b1;
               wt_addr_d   = '0;
               bias_en_d   = 1'b1;
               bias_addr_d = '0;
               act_en_d    = 1'b0;
               act_addr_d  = '0;
               sat_d       = 1'b0;
               flush_d     = FL_INIT;
               drain_d     = '0;
               cnt_d       = '0;
            end
         end
         S_LOAD: begin
            if (bias_en_q) begin
               if (bias_addr_q == BI_LAST) bias_en_d = 1'b0;
               else                        bias_addr_d = bias_addr_q + 1'b1;
            end
            if (wt_addr_q == WT_LAST) begin
               state_d   = S_DRAIN;
               wt_en_d   = 1'b0;
               bias_en_d = 1'b0;
               drain_d   = DR_INIT;
            end else begin
               wt_addr_d = wt_addr_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) begin
               state_d  = S_STREAM;
               act_en_d = !hold;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         S_STREAM: begin
            // Enabled cycles after saturation re-read N-1 and burn the flush budget.
            if (act_en_q) begin
               if (!sat_q) begin
                  if (act_addr_q == AC_LAST) sat_d = 1'b1;
                  else                       act_addr_d = act_addr_q + 1'b1;
               end else if (flush_q <= FL_W'(1)) begin
                  overrun = 1'b1;
               end else begin
                  flush_d = flush_q - 1'b1;
               end
            end
            // The final write takes priority over a coincident overrun.
            if (wr && (cnt_q == OB_LAST)) begin
               state_d  = S_FIN;
               done_d   = 1'b1;
               act_en_d = 1'b0;
            end else begin
               if (wr) cnt_d = cnt_q + 1'b1;
               if (overrun) begin
                  state_d  = S_FIN;
                  err_d    = 1'b1;
                  act_en_d = 1'b0;
               end else begin
                  act_en_d = !hold;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d      = (state_d != S_IDLE);
      wt_pipe_d   = ROM_LAT'({wt_pipe_q, wt_en_q});
      bias_pipe_d = ROM_LAT'({bias_pipe_q, bias_en_q});
   end

   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wt_en_q     <= 1'b0;
         wt_addr_q   <= '0;
         bias_en_q   <= 1'b0;
         bias_addr_q <= '0;
         act_en_q    <= 1'b0;
         act_addr_q  <= '0;
         sat_q       <= 1'b0;
         flush_q     <= '0;
         drain_q     <= '0;
         cnt_q       <= '0;
         wt_pipe_q   <= '0;
         bias_pipe_q <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         wt_en_q     <= wt_en_d;
         wt_addr_q   <= wt_addr_d;
         bias_en_q   <= bias_en_d;
         bias_addr_q <= bias_addr_d;
         act_en_q    <= act_en_d;
         act_addr_q  <= act_addr_d;
         sat_q       <= sat_d;
         flush_q     <= flush_d;
         drain_q     <= drain_d;
         cnt_q       <= cnt_d;
         wt_pipe_q   <= wt_pipe_d;
         bias_pipe_q <= bias_pipe_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign wt_en     = wt_en_q;
   assign wt_addr   = wt_addr_q;
   assign wt_load   = wt_pipe_q[ROM_LAT-1];
   assign bias_en   = bias_en_q;
   assign bias_addr = bias_addr_q;
   assign bias_load = bias_pipe_q[ROM_LAT-1];
   assign act_en    = act_en_q;
   assign act_addr  = act_addr_q;
   assign obuf_we   = wr;
   assign obuf_addr = cnt_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: cycle-level behavioural model checked every cycle,
// directed scenarios with literal timing expectations, then randomized runs.
module tb_conv_layer_sequencer;
   localparam int N = 20, K = 4, CHAN = 2, OUTLEN = 5, RL = 1, FM = 6;
   localparam int KC = K * CHAN;

   logic       clk = 1'b0;
   logic       global_rst, start, hold, conv_valid;
   logic       busy, done, err, wt_en, wt_load, bias_en, bias_load, act_en, obuf_we;
   logic [2:0] wt_addr;
   logic [0:0] bias_addr;
   logic [4:0] act_addr;
   logic [2:0] obuf_addr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   conv_layer_sequencer #(.N(N), .K(K), .CHAN(CHAN), .OUTLEN(OUTLEN), .ROM_LAT(RL), .FLUSH_MAX(FM)) dut (
      .clk(clk), .global_rst(global_rst), .start(start), .hold(hold),
      .busy(busy), .done(done), .err(err),
      .wt_en(wt_en), .wt_addr(wt_addr), .wt_load(wt_load),
      .bias_en(bias_en), .bias_addr(bias_addr), .bias_load(bias_load),
      .act_en(act_en), .act_addr(act_addr), .conv_valid(conv_valid),
      .obuf_we(obuf_we), .obuf_addr(obuf_addr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: position in the layer (t = cycles since start), enabled-cycle and write counts.
   bit m_active, m_fin, m_err, m_hold_prev;
   int m_t, m_e, m_w;

   always @(negedge clk) begin
      bit stream, ea, ew, ewe, ebe, ewl, ebl, live;
      int exp_addr;
      if (global_rst) begin
         chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
         chk("rst_err", err, 0);         chk("rst_wt_en", wt_en, 0);
         chk("rst_wt_addr", wt_addr, 0); chk("rst_wt_load", wt_load, 0);
         chk("rst_bias_en", bias_en, 0); chk("rst_bias_addr", bias_addr, 0);
         chk("rst_bias_load", bias_load, 0);
         chk("rst_act_en", act_en, 0);   chk("rst_act_addr", act_addr, 0);
         chk("rst_obuf_we", obuf_we, 0); chk("rst_obuf_addr", obuf_addr, 0);
         m_active = 0; m_fin = 0; m_err = 0; m_t = 0; m_e = 0; m_w = 0;
      end else begin
         live   = m_active && !m_fin;
         stream = live && (m_t >= KC + RL + 1);
         ea     = stream && !m_hold_prev;
         ew     = stream && conv_valid;
         ewe    = live && (m_t >= 1) && (m_t <= KC);
         ebe    = live && (m_t >= 1) && (m_t <= CHAN);
         ewl    = live && (m_t >= 1 + RL) && (m_t <= KC + RL);
         ebl    = live && (m_t >= 1 + RL) && (m_t <= CHAN + RL);
         chk("busy", busy, m_active);
         chk("done", done, m_fin && !m_err);
         chk("err", err, m_err);
         chk("wt_en", wt_en, ewe);
         chk("bias_en", bias_en, ebe);
         chk("wt_load", wt_load, ewl);
         chk("bias_load", bias_load, ebl);
         chk("act_en", act_en, ea);
         chk("obuf_we", obuf_we, ew);
         if (ewe) chk("wt_addr", wt_addr, m_t - 1);
         if (ebe) chk("bias_addr", bias_addr, m_t - 1);
         if (stream) begin
            exp_addr = (m_e < N - 1) ? m_e : N - 1;
            chk("act_addr", act_addr, exp_addr);
         end
         if (ew) chk("obuf_addr", obuf_addr, m_w);
         if (!m_active) begin
            if (start) begin
               m_active = 1; m_fin = 0; m_err = 0; m_t = 1; m_e = 0; m_w = 0;
            end
         end else if (m_fin) begin
            m_active = 0; m_fin = 0;
         end else begin
            if (ea) m_e++;
            if (ew) m_w++;
            if (m_w == OUTLEN) m_fin = 1;
            else if (ea && (m_e == N + FM)) begin
               m_fin = 1; m_err = 1;
            end
            m_t++;
         end
      end
      m_hold_prev = hold;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pv, ph, rst_at, i;
      global_rst = 1; start = 0; hold = 0; conv_valid = 0;
      step(); step();
      global_rst = 0;
      step(); step();

      // A: basic timing and normal completion
      start = 1; step(); start = 0;
      for (int c = 1; c <= 18; c++) begin
         conv_valid = (c >= 11 && c <= 15);
         @(negedge clk);
         case (c)
            1:  begin chk("A_wt_addr1", wt_addr, 0); chk("A_wt_load1", wt_load, 0); chk("A_bias_addr1", bias_addr, 0); end
            2:  begin chk("A_wt_load2", wt_load, 1); chk("A_bias_addr2", bias_addr, 1); end
            3:  chk("A_bias_en3", bias_en, 0);
            8:  chk("A_wt_addr8", wt_addr, 7);
            9:  begin chk("A_wt_load9", wt_load, 1); chk("A_act_en9", act_en, 0); end
            10: begin chk("A_wt_load10", wt_load, 0); chk("A_act_en10", act_en, 1); end
            15: chk("A_obuf_addr15", obuf_addr, 4);
            16: chk("A_done16", done, 1);
            17: begin chk("A_done17", done, 0); chk("A_busy17", busy, 0); end
            default: ;
         endcase
         step();
      end
      conv_valid = 0;

      // B: hold for three cycles mid-stream
      start = 1; step(); start = 0;
      for (int c = 1; c <= 27; c++) begin
         hold = (c >= 12 && c <= 14);
         conv_valid = (c >= 20 && c <= 24);
         @(negedge clk);
         case (c)
            12: begin chk("B_act_en12", act_en, 1); chk("B_act_addr12", act_addr, 2); end
            13: chk("B_act_en13", act_en, 0);
            14: chk("B_act_en14", act_en, 0);
            15: begin chk("B_act_en15", act_en, 0); chk("B_act_addr15", act_addr, 3); end
            16: begin chk("B_act_en16", act_en, 1); chk("B_act_addr16", act_addr, 3); end
            17: chk("B_act_addr17", act_addr, 4);
            25: chk("B_done25", done, 1);
            default: ;
         endcase
         step();
      end
      hold = 0; conv_valid = 0;

      // C: too few results -> overrun
      start = 1; step(); start = 0;
      for (int c = 1; c <= 40; c++) begin
         conv_valid = (c >= 11 && c <= 13);
         @(negedge clk);
         case (c)
            34: chk("C_act_addr34", act_addr, 19);
            35: chk("C_err35", err, 0);
            36: begin chk("C_err36", err, 1); chk("C_done36", done, 0); end
            37: begin chk("C_busy37", busy, 0); chk("C_err37", err, 1); end
            default: ;
         endcase
         step();
      end
      conv_valid = 0;

      // D: restart clears err, then reset during LOAD at wt_addr=3
      start = 1;
      @(negedge clk);
      chk("D_err0", err, 1);
      step(); start = 0;
      for (int c = 1; c <= 10; c++) begin
         global_rst = (c == 4 || c == 5);
         @(negedge clk);
         if (c == 1) chk("D_err1", err, 0);
         if (c == 3) chk("D_wt_addr3", wt_addr, 2);
         if (c == 4) begin chk("D_wt_en4", wt_en, 0); chk("D_busy4", busy, 0); end
         if (c >= 5) chk("D_wt_load_after_rst", wt_load, 0);
         step();
      end
      start = 1; step(); start = 0;
      for (int c = 1; c <= 18; c++) begin
         conv_valid = (c >= 11 && c <= 15);
         @(negedge clk);
         if (c == 1) begin chk("D_wt_addr_restart", wt_addr, 0); chk("D_wt_en_restart", wt_en, 1); end
         if (c == 16) chk("D_done16", done, 1);
         step();
      end
      conv_valid = 0;

      // E: conv_valid in IDLE/LOAD and a second start during LOAD
      conv_valid = 1;
      step(); step(); step();
      for (int c = 0; c <= 17; c++) begin
         start = (c == 0 || c == 3);
         conv_valid = (c <= 9) || (c >= 11 && c <= 15);
         @(negedge clk);
         case (c)
            3:  chk("E_obuf_we3", obuf_we, 0);
            5:  chk("E_wt_addr5", wt_addr, 4);
            9:  chk("E_act_en9", act_en, 0);
            10: chk("E_act_en10", act_en, 1);
            16: chk("E_done16", done, 1);
            default: ;
         endcase
         step();
      end
      start = 0; conv_valid = 0;

      // Randomized runs
      for (int r = 0; r < 40; r++) begin
         pv = $urandom_range(5, 45);
         ph = $urandom_range(0, 40);
         rst_at = (r % 8 == 5) ? int'($urandom_range(2, 40)) : -1;
         repeat ($urandom_range(1, 4)) begin
            conv_valid = ($urandom_range(0, 99) < 30);
            step();
         end
         start = 1; step(); start = 0;
         for (i = 0; i < 200; i++) begin
            global_rst = (i == rst_at);
            if (!m_active) begin
               start = 0; hold = 0; conv_valid = 0;
               break;
            end
            hold       = ($urandom_range(0, 99) < ph);
            conv_valid = ($urandom_range(0, 99) < pv);
            start      = ($urandom_range(0, 19) == 0);
            step();
         end
         global_rst = 0; start = 0; hold = 0; conv_valid = 0;
         chk("run_timeout", m_active, 0);
         step();
      end

      step(); step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Control FSM for one convolution layer. It sequences the parameter preload from the weight and bias ROMs, then the activation stream into the parallel convolver bank. It counts convolver results into the layer output buffer and reports completion or overrun. It replaces the free-running address counters around the per-channel convolvers with an explicit start/busy/done handshake and a downstream hold.

## Interface
Parameters:
- N, 21504, activation words per layer (activation ROM depth)
- K, 32, kernel taps per channel
- CHAN, 4, output channels (parallel convolvers)
- OUTLEN, 2562, results expected per channel
- ROM_LAT, 1, ROM read latency in cycles (1 or 2)
- FLUSH_MAX, 64, extra cycles allowed after last activation before overrun

Ports:
- clk  in  1  rising-edge clock
- global_rst  in  1  asynchronous reset, active-high
- start  in  1  begin layer; sampled only in IDLE
- hold  in  1  downstream back-pressure; freezes activation stream
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at normal completion
- err  out  1  sticky overrun flag; cleared by next accepted start
- wt_en  out  1  weight ROM enable
- wt_addr  out  clog2(K*CHAN)  weight ROM address
- wt_load  out  1  weight ROM data valid; shift into weight register
- bias_en  out  1  bias ROM enable
- bias_addr  out  clog2(CHAN)  bias ROM address
- bias_load  out  1  bias ROM data valid
- act_en  out  1  activation ROM enable and convolver ce
- act_addr  out  clog2(N)  activation ROM address
- conv_valid  in  1  convolver result valid (common to all channels)
- obuf_we  out  1  output buffer write enable
- obuf_addr  out  clog2(OUTLEN)  output buffer write address

## Operation
- States: IDLE, LOAD, DRAIN, STREAM, FIN.
- IDLE: all enables low. start=1 causes a transition to LOAD, clears err, and zeroes all counters.
- LOAD: lasts K*CHAN cycles.
  - wt_en=1 and wt_addr=0..K*CHAN-1, one per cycle.
  - bias_en=1 and bias_addr=0..CHAN-1 during the first CHAN cycles.
- DRAIN: lasts ROM_LAT cycles with no ROM enables, letting the final reads land.
- Load strobes: wt_load and bias_load are the corresponding en delayed by ROM_LAT cycles. A total of exactly K*CHAN wt_load pulses and CHAN bias_load pulses are issued.
- STREAM: act_en = !hold.
  - act_addr increments on each cycle where act_en=1.
  - act_addr saturates at N-1 after N enabled cycles. Further enabled cycles re-read N-1 to flush the convolver pipeline.
- Output writes: in STREAM, obuf_we = conv_valid and obuf_addr = output count. The count increments on each write.
  - conv_valid outside STREAM is ignored (no write).
- STREAM exit, normal: the write making count = OUTLEN leads to FIN.
- STREAM exit, overrun: FLUSH_MAX enabled cycles elapse after act_addr saturates without reaching OUTLEN. err is set and the FSM goes to FIN.
- FIN: done=1 for one cycle only if err is 0; then IDLE.
- hold does not pause LOAD/DRAIN.
- start outside IDLE is ignored.
- Reset mid-operation: the FSM returns to IDLE immediately, no done, and pending load strobes are discarded.

## Timing
- All outputs are registered except obuf_we/obuf_addr, which are combinational from conv_valid and the count register.
- Reset values: every output 0, state IDLE, all counters 0, err 0.
- Start at cycle 0:
  - cycles 1..K*CHAN are LOAD;
  - the first wt_load is at cycle 1+ROM_LAT;
  - STREAM begins at cycle K*CHAN+ROM_LAT+1, with act_en high that cycle if hold=0.
- busy rises at cycle 1 and falls with the FIN cycle (busy=0 the cycle after FIN).
- hold asserted in cycle t leads to act_en=0 in cycle t+1. act_addr does not advance while act_en=0.
- Simultaneous final conv_valid and overrun condition in the same cycle: the write wins, err stays 0, done pulses.
- Counter widths hold full range without wrap. The output count never exceeds OUTLEN.

## Test plan
Use K=4, CHAN=2, N=20, OUTLEN=5, ROM_LAT=1, FLUSH_MAX=6 unless stated.
- Start at cycle 0 -> wt_addr steps 0..7 in cycles 1..8, wt_load in cycles 2..9, bias_addr 0,1 in cycles 1,2, first act_en at cycle 10.
- conv_valid pulses 5 times during STREAM -> obuf_addr 0..4 written, done=1 for one cycle after the 5th write, busy low the following cycle.
- hold=1 for 3 cycles mid-stream -> act_en low for exactly 3 cycles starting one cycle later, act_addr unchanged across the gap.
- Only 3 conv_valid pulses -> act_addr holds 19, err=1 after 6 flush cycles, no done, FSM reaches IDLE. A following start clears err.
- global_rst asserted during LOAD at wt_addr=3 -> all outputs 0 immediately, no wt_load pulses after reset. A following start restarts at wt_addr=0.
- conv_valid and start during IDLE or LOAD -> no obuf_we. The second start is ignored and the sequence timing is unchanged.
